// File: rtl/load_store_unit.sv
// Memory stage of the RV32I pipeline: one data-memory transaction per op over a
// valid/ready request bus, with byte-lane steering, alignment checks and a response timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_rw,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic        is_load, is_load_d;
  logic [2:0]  f3, f3_d;
  logic [1:0]  off, off_d;

  logic        busy_d, done_d, err_d, req_valid_d, we_d;
  logic [1:0]  cause_d;
  logic [31:0] rdata_d, bus_addr_d, bus_wdata_d;
  logic [3:0]  wstrb_d;

  logic        legal, misaligned, timeout_hit;
  logic [3:0]  st_strb;
  logic [31:0] st_data, ld_word, ld_ext;

  always_comb begin
    if (mem_rw) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b101);
  end

  // funct3[1:0] encodes the access width for every legal op: 00 byte, 01 half, 10 word
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    case (funct3[1:0])
      2'b00:   begin st_strb = 4'b0001 << addr[1:0]; st_data = {4{wdata_in[7:0]}};  end
      2'b01:   begin st_strb = 4'b0011 << addr[1:0]; st_data = {2{wdata_in[15:0]}}; end
      default: begin st_strb = 4'b1111;              st_data = wdata_in;            end
    endcase
  end

  assign ld_word = bus_rdata >> {off, 3'b000};

  always_comb begin
    case (f3)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b100:  ld_ext = {24'h0, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b101:  ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  assign timeout_hit = (cnt == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    is_load_d   = is_load;
    f3_d        = f3;
    off_d       = off;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cause_d     = err_cause;
    rdata_d     = rdata_out;
    req_valid_d = bus_req_valid;
    bus_addr_d  = bus_addr;
    we_d        = bus_we;
    wstrb_d     = bus_wstrb;
    bus_wdata_d = bus_wdata;
    case (state)
      IDLE: begin
        if (start) begin
          if (!legal) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            cause_d = 2'b10;
          end else if (misaligned) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            cause_d = 2'b01;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            is_load_d   = !mem_rw;
            f3_d        = funct3;
            off_d       = addr[1:0];
            req_valid_d = 1'b1;
            bus_addr_d  = {addr[31:2], 2'b00};
            we_d        = mem_rw;
            wstrb_d     = mem_rw ? st_strb : 4'b0000;
            bus_wdata_d = mem_rw ? st_data : '0;
          end
        end
      end
      REQ: begin
        // Timeout wins over a handshake in the same cycle so the budget is never exceeded
        if (timeout_hit) begin
          state_d     = IDLE;
          req_valid_d = 1'b0;
          done_d      = 1'b1;
          err_d       = 1'b1;
          cause_d     = 2'b11;
        end else begin
          cnt_d = cnt + 16'd1;
          if (bus_req_ready) begin
            state_d     = RESP;
            req_valid_d = 1'b0;
          end
        end
      end
      RESP: begin
        if (bus_rsp_valid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cause_d = 2'b00;
          if (is_load) rdata_d = ld_ext;
        end else if (timeout_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      is_load       <= 1'b0;
      f3            <= '0;
      off           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_cause     <= '0;
      rdata_out     <= '0;
      bus_req_valid <= 1'b0;
      bus_addr      <= '0;
      bus_we        <= 1'b0;
      bus_wstrb     <= '0;
      bus_wdata     <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      is_load       <= is_load_d;
      f3            <= f3_d;
      off           <= off_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      err_cause     <= cause_d;
      rdata_out     <= rdata_d;
      bus_req_valid <= req_valid_d;
      bus_addr      <= bus_addr_d;
      bus_we        <= we_d;
      bus_wstrb     <= wstrb_d;
      bus_wdata     <= bus_wdata_d;
    end
  end

endmodule
